// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
// Range codes, divider ratio and the measurement FSM states.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam logic RANGE_X1    = 1'b0;
  localparam logic RANGE_DIV10 = 1'b1;

  localparam int unsigned DIV_RATIO = 10;

endpackage

// File: rtl/freq_meter_auto_bcd_counter.sv
// Cascaded decimal counter with ripple carry inside one cycle.
// Saturates at all nines and raises ovf instead of wrapping.
module bcd_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] count,
  output logic                ovf
);

  logic [4*DIGITS-1:0] cnt_q;
  logic [4*DIGITS-1:0] cnt_d;
  logic                ovf_q;
  logic                ovf_d;
  logic                all9;
  logic                carry;

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    carry = 1'b0;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc && all9) begin
      ovf_d = 1'b1;
    end else begin
      carry = inc;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (carry) begin
          if (cnt_q[4*i +: 4] == 4'd9) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/freq_meter_auto.sv
// Gated edge counter with x1 / div10 ranges and auto-ranging.
// Publishes a packed BCD result with a one-cycle valid pulse.
module freq_meter_auto
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned DIGITS      = 4
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                sig_in,
  input  logic                auto_en,
  input  logic                range_sel,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                range_out,
  output logic                overflow,
  output logic                valid
);

  localparam int unsigned TW = $clog2(GATE_CYCLES);

  logic [2:0]          sync_q;
  logic [2:0]          sync_d;
  logic                edge_p;

  state_e              state_q;
  state_e              state_d;
  logic [TW-1:0]       timer_q;
  logic [TW-1:0]       timer_d;
  logic [3:0]          presc_q;
  logic [3:0]          presc_d;
  logic                range_q;
  logic                range_d;
  logic                mode_q;
  logic                mode_d;
  logic                auto_q;
  logic                auto_d;

  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_d;
  logic                rout_q;
  logic                rout_d;
  logic                ovfo_q;
  logic                ovfo_d;
  logic                valid_q;
  logic                valid_d;

  logic                clr;
  logic                inc;
  logic                publish;
  logic [4*DIGITS-1:0] cnt;
  logic                cnt_ovf;

  // Two sync stages, third stage is the edge-detect history.
  assign sync_d = {sync_q[1:0], sig_in};
  assign edge_p = sync_q[1] & ~sync_q[2];

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_cnt (
    .sysclk (sysclk),
    .rst    (rst),
    .clr    (clr),
    .inc    (inc),
    .count  (cnt),
    .ovf    (cnt_ovf)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    presc_d = presc_q;
    range_d = range_q;
    mode_d  = mode_q;
    auto_d  = auto_q;
    bcd_d   = bcd_q;
    rout_d  = rout_q;
    ovfo_d  = ovfo_q;
    valid_d = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    publish = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr     = 1'b1;
        timer_d = '0;
        presc_d = '0;
        mode_d  = auto_en;
        range_d = auto_en ? auto_q : range_sel;
        state_d = ST_GATE;
      end
      ST_GATE: begin
        if (edge_p) begin
          if (range_q == RANGE_X1) begin
            inc = 1'b1;
          end else if (presc_q == 4'(DIV_RATIO - 1)) begin
            inc     = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 4'd1;
          end
        end
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(GATE_CYCLES - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_CLEAR;
        publish = 1'b1;
        if (mode_q) begin
          // Overrange in x1 is discarded and remeasured in div10.
          if (range_q == RANGE_X1 && cnt_ovf) begin
            auto_d  = RANGE_DIV10;
            publish = 1'b0;
          end else if (range_q == RANGE_DIV10 &&
                       cnt[4*DIGITS-1 -: 4] == 4'd0) begin
            auto_d = RANGE_X1;
          end
        end
        if (publish) begin
          bcd_d   = cnt;
          rout_d  = range_q;
          ovfo_d  = cnt_ovf;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= ST_CLEAR;
      timer_q <= '0;
      presc_q <= '0;
      range_q <= RANGE_X1;
      mode_q  <= 1'b0;
      auto_q  <= RANGE_X1;
      bcd_q   <= '0;
      rout_q  <= 1'b0;
      ovfo_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      range_q <= range_d;
      mode_q  <= mode_d;
      auto_q  <= auto_d;
      bcd_q   <= bcd_d;
      rout_q  <= rout_d;
      ovfo_q  <= ovfo_d;
      valid_q <= valid_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign range_out = rout_q;
  assign overflow  = ovfo_q;
  assign valid     = valid_q;

endmodule
